// File: rtl/alu.sv
// alu: combinational ALU (compute ops drive Result, compare ops drive Flag)
// with registered copies of both outputs.
module alu #(
    parameter int N    = 32,
    parameter int logN = 5
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [4:0]   ALUOp,
    output logic [N-1:0] Result,
    output logic         Flag,
    output logic [N-1:0] Result_q,
    output logic         Flag_q
);
    logic [logN-1:0] sh;
    logic            lts;
    logic            ltu;
    logic            eq;
    assign sh  = B[logN-1:0];
    assign lts = $signed(A) < $signed(B);
    assign ltu = A < B;
    assign eq  = A == B;
    always_comb begin
        Result = '0;
        Flag   = 1'b0;
        case (ALUOp)
            5'b00000: Result = A + B;
            5'b01000: Result = A - B;
            5'b00100: Result = A ^ B;
            5'b00110: Result = A | B;
            5'b00111: Result = A & B;
            5'b00001: Result = A << sh;
            5'b00101: Result = A >> sh;
            5'b01101: Result = $signed(A) >>> sh;
            5'b00010: Result = {{(N-1){1'b0}}, lts};
            5'b00011: Result = {{(N-1){1'b0}}, ltu};
            5'b11000: Flag = eq;
            5'b11001: Flag = !eq;
            5'b11100: Flag = lts;
            5'b11101: Flag = !lts;
            5'b11110: Flag = ltu;
            5'b11111: Flag = !ltu;
            default: ;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            Result_q <= '0;
            Flag_q   <= 1'b0;
        end else begin
            Result_q <= Result;
            Flag_q   <= Flag;
        end
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vector table plus randomized ops against an integer-arithmetic model.
module tb_alu;
    localparam int N = 4;
    localparam int LOGN = 2;

    logic         clock;
    logic         reset_n;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [4:0]   ALUOp;
    logic [N-1:0] Result;
    logic         Flag;
    logic [N-1:0] Result_q;
    logic         Flag_q;

    int checks = 0;
    int failures = 0;
    logic [N-1:0] prev_res;
    logic         prev_flag;
    bit           have_prev = 0;

    alu #(.N(N), .logN(LOGN)) dut (
        .clock(clock), .reset_n(reset_n), .A(A), .B(B), .ALUOp(ALUOp),
        .Result(Result), .Flag(Flag), .Result_q(Result_q), .Flag_q(Flag_q)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        string      name;
        logic [4:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       flag;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sval(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    // Reference built from arithmetic definitions: shifts as multiply/floor-divide by 2^s.
    task automatic model(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] res, output logic flag);
        int ua, ub, sa, sb, d, q;
        ua = int'(a);
        ub = int'(b);
        sa = sval(a);
        sb = sval(b);
        d = 1;
        for (int i = 0; i < (ub % 4); i++) d = d * 2;
        res = 0;
        flag = 0;
        case (op)
            5'b00000: res = 4'((ua + ub) % 16);
            5'b01000: res = 4'((ua - ub + 16) % 16);
            5'b00100: res = a ^ b;
            5'b00110: res = a | b;
            5'b00111: res = a & b;
            5'b00001: res = 4'((ua * d) % 16);
            5'b00101: res = 4'(ua / d);
            5'b01101: begin
                q = sa / d;
                if (sa < 0 && (sa % d) != 0) q = q - 1;
                res = 4'(q);
            end
            5'b00010: res = (sa < sb) ? 4'd1 : 4'd0;
            5'b00011: res = (ua < ub) ? 4'd1 : 4'd0;
            5'b11000: flag = (ua == ub);
            5'b11001: flag = (ua != ub);
            5'b11100: flag = (sa < sb);
            5'b11101: flag = (sa >= sb);
            5'b11110: flag = (ua < ub);
            5'b11111: flag = (ua >= ub);
            default: ;
        endcase
    endtask

    task automatic apply(input string name, input logic [4:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] eres, input logic eflag);
        @(posedge clock);
        #1;
        if (have_prev) begin
            chk({name, "/Result_q_prev"}, int'(Result_q), int'(prev_res));
            chk({name, "/Flag_q_prev"}, int'(Flag_q), int'(prev_flag));
        end
        ALUOp = op;
        A = a;
        B = b;
        @(negedge clock);
        chk({name, "/Result"}, int'(Result), int'(eres));
        chk({name, "/Flag"}, int'(Flag), int'(eflag));
        prev_res = eres;
        prev_flag = eflag;
        have_prev = 1;
    endtask

    initial begin
        logic [3:0] r;
        logic       f;
        logic [4:0] op;
        logic [3:0] a, b;
        vecs.push_back('{"add_wrap", 5'b00000, 4'b1111, 4'b0001, 4'b0000, 1'b0});
        vecs.push_back('{"sub_wrap", 5'b01000, 4'b0000, 4'b0001, 4'b1111, 1'b0});
        vecs.push_back('{"srl", 5'b00101, 4'b1000, 4'b0101, 4'b0100, 1'b0});
        vecs.push_back('{"sra", 5'b01101, 4'b1000, 4'b0101, 4'b1100, 1'b0});
        vecs.push_back('{"sll", 5'b00001, 4'b1000, 4'b0101, 4'b0000, 1'b0});
        vecs.push_back('{"sra_zero", 5'b01101, 4'b1000, 4'b0100, 4'b1000, 1'b0});
        vecs.push_back('{"lts", 5'b11100, 4'b1111, 4'b0001, 4'b0000, 1'b1});
        vecs.push_back('{"ltu", 5'b11110, 4'b1111, 4'b0001, 4'b0000, 1'b0});
        vecs.push_back('{"geu", 5'b11111, 4'b1111, 4'b0001, 4'b0000, 1'b1});
        vecs.push_back('{"slts", 5'b00010, 4'b1111, 4'b0001, 4'b0001, 1'b0});
        vecs.push_back('{"sltu", 5'b00011, 4'b1111, 4'b0001, 4'b0000, 1'b0});
        vecs.push_back('{"eq", 5'b11000, 4'b0101, 4'b0101, 4'b0000, 1'b1});
        vecs.push_back('{"ne", 5'b11001, 4'b0101, 4'b0101, 4'b0000, 1'b0});
        vecs.push_back('{"unused", 5'b10000, 4'b0101, 4'b0011, 4'b0000, 1'b0});
        vecs.push_back('{"lts_minneg", 5'b11100, 4'b1000, 4'b0111, 4'b0000, 1'b1});
        vecs.push_back('{"ges_minneg", 5'b11101, 4'b1000, 4'b1000, 4'b0000, 1'b1});
        vecs.push_back('{"xor", 5'b00100, 4'b1100, 4'b1010, 4'b0110, 1'b0});
        vecs.push_back('{"or", 5'b00110, 4'b1100, 4'b1010, 4'b1110, 1'b0});
        vecs.push_back('{"and", 5'b00111, 4'b1100, 4'b1010, 4'b1000, 1'b0});

        reset_n = 1;
        ALUOp = 5'b00000;
        A = 4'b0011;
        B = 4'b0001;
        #3 reset_n = 0;
        #1;
        chk("reset_init/Result_q", int'(Result_q), 0);
        chk("reset_init/Flag_q", int'(Flag_q), 0);
        chk("reset_init/Result_comb", int'(Result), 4);
        @(negedge clock);
        reset_n = 1;

        foreach (vecs[i])
            apply(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flag);

        for (int i = 0; i < 300; i++) begin
            op = 5'($urandom_range(0, 31));
            a = 4'($urandom);
            b = 4'($urandom);
            model(op, a, b, r, f);
            apply($sformatf("rand%0d_op%b_a%b_b%b", i, op, a, b), op, a, b, r, f);
        end

        // Mid-cycle async reset: outputs clear without an edge, comb path unaffected.
        ALUOp = 5'b11111;
        A = 4'b0010;
        B = 4'b0001;
        @(negedge clock);
        #2 reset_n = 0;
        #1;
        chk("midreset/Result_q", int'(Result_q), 0);
        chk("midreset/Flag_q", int'(Flag_q), 0);
        chk("midreset/Flag_comb", int'(Flag), 1);
        repeat (2) @(posedge clock);
        #1;
        chk("hold_reset/Result_q", int'(Result_q), 0);
        chk("hold_reset/Flag_q", int'(Flag_q), 0);
        have_prev = 0;
        @(negedge clock);
        reset_n = 1;
        apply("post_reset_add", 5'b00000, 4'b0011, 4'b0100, 4'b0111, 1'b0);
        apply("post_reset_eq", 5'b11000, 4'b0110, 4'b0110, 4'b0000, 1'b1);
        @(posedge clock);
        #1;
        chk("final/Result_q", int'(Result_q), 0);
        chk("final/Flag_q", int'(Flag_q), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
